// File: rtl/fetch_decode_skid_if.sv
// Valid/ready handshake carrying one fetched instruction with its PC and PC+4.
// Producers use the master modport and consumers use the slave modport.
interface fetch_decode_skid_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus;

    modport master (output valid, instr, pc, pc_plus, input ready);
    modport slave  (input valid, instr, pc, pc_plus, output ready);
endinterface

// File: rtl/fetch_decode_skid.sv
// Two-entry skid buffer between fetch and decode. in_ready is a pure flop output,
// and decode-side outputs come straight from the main register.
module fetch_decode_skid #(
    parameter int                    DATA_WIDTH        = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR         = DATA_WIDTH'(32'h0000_0013),
    parameter bit                    ZERO_PC_ON_BUBBLE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    fetch_decode_skid_if.slave         in_if,
    fetch_decode_skid_if.master        out_if,
    output logic [1:0]                 occ
);

    logic                  main_valid_q, main_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] main_instr_q, main_instr_d;
    logic [DATA_WIDTH-1:0] main_pc_q, main_pc_d;
    logic [DATA_WIDTH-1:0] main_pc_plus_q, main_pc_plus_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_WIDTH-1:0] skid_pc_plus_q, skid_pc_plus_d;
    logic                  accept;
    logic                  drain;

    assign accept = in_if.valid && !skid_valid_q;
    assign drain  = main_valid_q && out_if.ready;

    always_comb begin
        main_valid_d   = main_valid_q;
        skid_valid_d   = skid_valid_q;
        main_instr_d   = main_instr_q;
        main_pc_d      = main_pc_q;
        main_pc_plus_d = main_pc_plus_q;
        skid_instr_d   = skid_instr_q;
        skid_pc_d      = skid_pc_q;
        skid_pc_plus_d = skid_pc_plus_q;

        if (flush) begin
            // Payloads keep their contents so a held PC stays visible when bubbles don't zero it.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || (drain && !skid_valid_q)) begin
            main_valid_d = accept;
            if (accept) begin
                main_instr_d   = in_if.instr;
                main_pc_d      = in_if.pc;
                main_pc_plus_d = in_if.pc_plus;
            end
        end else if (drain) begin
            // Skid is valid here, so in_ready is low and no accept can race the move.
            main_valid_d   = 1'b1;
            skid_valid_d   = 1'b0;
            main_instr_d   = skid_instr_q;
            main_pc_d      = skid_pc_q;
            main_pc_plus_d = skid_pc_plus_q;
        end else if (accept) begin
            skid_valid_d   = 1'b1;
            skid_instr_d   = in_if.instr;
            skid_pc_d      = in_if.pc;
            skid_pc_plus_d = in_if.pc_plus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q   <= 1'b0;
            skid_valid_q   <= 1'b0;
            main_instr_q   <= '0;
            main_pc_q      <= '0;
            main_pc_plus_q <= '0;
            skid_instr_q   <= '0;
            skid_pc_q      <= '0;
            skid_pc_plus_q <= '0;
        end else begin
            main_valid_q   <= main_valid_d;
            skid_valid_q   <= skid_valid_d;
            main_instr_q   <= main_instr_d;
            main_pc_q      <= main_pc_d;
            main_pc_plus_q <= main_pc_plus_d;
            skid_instr_q   <= skid_instr_d;
            skid_pc_q      <= skid_pc_d;
            skid_pc_plus_q <= skid_pc_plus_d;
        end
    end

    assign in_if.ready     = !skid_valid_q;
    assign out_if.valid    = main_valid_q;
    assign out_if.instr    = main_valid_q ? main_instr_q : NOP_INSTR;
    assign out_if.pc       = (main_valid_q || !ZERO_PC_ON_BUBBLE) ? main_pc_q : '0;
    assign out_if.pc_plus  = (main_valid_q || !ZERO_PC_ON_BUBBLE) ? main_pc_plus_q : '0;
    assign occ             = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_fetch_decode_skid.sv
// Directed bench for fetch_decode_skid: a default 32-bit instance and a
// 64-bit instance that holds its PC on bubbles.
module tb_fetch_decode_skid;

    logic       clk;
    logic       rst_n;
    logic       flush0;
    logic       flush1;
    logic [1:0] occ0;
    logic [1:0] occ1;
    int         n_cmp;
    int         n_err;

    fetch_decode_skid_if #(.DATA_WIDTH(32)) f0_in ();
    fetch_decode_skid_if #(.DATA_WIDTH(32)) f0_out ();
    fetch_decode_skid_if #(.DATA_WIDTH(64)) f1_in ();
    fetch_decode_skid_if #(.DATA_WIDTH(64)) f1_out ();

    fetch_decode_skid dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush0),
        .in_if  (f0_in),
        .out_if (f0_out),
        .occ    (occ0)
    );

    fetch_decode_skid #(
        .DATA_WIDTH        (64),
        .ZERO_PC_ON_BUBBLE (1'b0)
    ) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush1),
        .in_if  (f1_in),
        .out_if (f1_out),
        .occ    (occ1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc);
        f0_in.valid   = v;
        f0_in.pc      = pc;
        f0_in.instr   = 32'hA000_0000 | pc;
        f0_in.pc_plus = pc + 32'd4;
    endtask

    task automatic expect_entry(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, 64'(f0_out.valid), 64'd1);
        check({tag, ".pc"}, 64'(f0_out.pc), 64'(pc));
        check({tag, ".instr"}, 64'(f0_out.instr), 64'(32'hA000_0000 | pc));
        check({tag, ".pc_plus"}, 64'(f0_out.pc_plus), 64'(pc + 32'd4));
    endtask

    task automatic expect_bubble(input string tag);
        check({tag, ".valid"}, 64'(f0_out.valid), 64'd0);
        check({tag, ".occ"}, 64'(occ0), 64'd0);
        check({tag, ".instr"}, 64'(f0_out.instr), 64'h13);
        check({tag, ".pc"}, 64'(f0_out.pc), 64'd0);
        check({tag, ".pc_plus"}, 64'(f0_out.pc_plus), 64'd0);
        check({tag, ".in_ready"}, 64'(f0_in.ready), 64'd1);
    endtask

    initial begin
        clk    = 1'b0;
        rst_n  = 1'b0;
        flush0 = 1'b0;
        flush1 = 1'b0;
        n_cmp  = 0;
        n_err  = 0;
        offer(1'b0, 32'h0);
        f0_out.ready  = 1'b1;
        f1_in.valid   = 1'b0;
        f1_in.instr   = '0;
        f1_in.pc      = '0;
        f1_in.pc_plus = '0;
        f1_out.ready  = 1'b1;

        // Reset values appear with no clock edge yet.
        #2;
        expect_bubble("rst");
        check("rst1.pc", f1_out.pc, 64'd0);
        check("rst1.instr", f1_out.instr, 64'h13);

        // Release before the first edge; that edge accepts the first entry.
        #1 rst_n = 1'b1;
        offer(1'b1, 32'h0);
        tick();
        expect_entry("str0", 32'h0);
        check("str0.occ", 64'(occ0), 64'd1);
        check("str0.in_ready", 64'(f0_in.ready), 64'd1);
        offer(1'b1, 32'h4);
        tick();
        expect_entry("str4", 32'h4);
        check("str4.occ", 64'(occ0), 64'd1);
        offer(1'b1, 32'h8);
        tick();
        expect_entry("str8", 32'h8);
        check("str8.occ", 64'(occ0), 64'd1);
        check("str8.in_ready", 64'(f0_in.ready), 64'd1);
        offer(1'b0, 32'h0);
        tick();
        expect_bubble("str_end");

        // Stall fill: decode stalled, three offers.
        f0_out.ready = 1'b0;
        offer(1'b1, 32'h10);
        tick();
        expect_entry("fill1", 32'h10);
        check("fill1.occ", 64'(occ0), 64'd1);
        check("fill1.in_ready", 64'(f0_in.ready), 64'd1);
        offer(1'b1, 32'h14);
        tick();
        expect_entry("fill2", 32'h10);
        check("fill2.occ", 64'(occ0), 64'd2);
        check("fill2.in_ready", 64'(f0_in.ready), 64'd0);
        offer(1'b1, 32'h18);
        tick();
        expect_entry("fill3", 32'h10);
        check("fill3.occ", 64'(occ0), 64'd2);
        check("fill3.in_ready", 64'(f0_in.ready), 64'd0);

        // Stall release: 0x18 is still being offered.
        f0_out.ready = 1'b1;
        tick();
        expect_entry("rel14", 32'h14);
        check("rel14.occ", 64'(occ0), 64'd1);
        check("rel14.in_ready", 64'(f0_in.ready), 64'd1);
        tick();
        expect_entry("rel18", 32'h18);
        check("rel18.occ", 64'(occ0), 64'd1);
        offer(1'b0, 32'h0);
        tick();
        expect_bubble("rel_end");

        // Flush with one entry held and a real accept in the same cycle.
        f0_out.ready = 1'b0;
        offer(1'b1, 32'h60);
        tick();
        expect_entry("fl1_pre", 32'h60);
        flush0 = 1'b1;
        offer(1'b1, 32'h64);
        tick();
        expect_bubble("fl1");
        flush0 = 1'b0;
        offer(1'b0, 32'h0);
        tick();
        expect_bubble("fl1_after");

        // Flush with both entries held plus an offer of 0x20.
        offer(1'b1, 32'h30);
        tick();
        offer(1'b1, 32'h34);
        tick();
        check("fl2_pre.occ", 64'(occ0), 64'd2);
        flush0 = 1'b1;
        offer(1'b1, 32'h20);
        tick();
        expect_bubble("fl2");
        flush0 = 1'b0;
        offer(1'b0, 32'h0);
        f0_out.ready = 1'b1;
        tick();
        expect_bubble("fl2_after");

        // Asynchronous reset mid-cycle with both entries held.
        f0_out.ready = 1'b0;
        offer(1'b1, 32'h40);
        tick();
        offer(1'b1, 32'h44);
        tick();
        check("ar_pre.occ", 64'(occ0), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        expect_bubble("ar");
        rst_n = 1'b1;
        f0_out.ready = 1'b1;
        offer(1'b1, 32'h50);
        tick();
        expect_entry("ar_first", 32'h50);
        check("ar_first.occ", 64'(occ0), 64'd1);
        offer(1'b0, 32'h0);
        tick();
        expect_bubble("ar_end");

        // 64-bit instance: full-width payload and PC held after the drain.
        f1_in.valid   = 1'b1;
        f1_in.instr   = 64'h1234_5678_9ABC_DEF0;
        f1_in.pc      = 64'hDEAD_BEEF_0000_0100;
        f1_in.pc_plus = 64'hDEAD_BEEF_0000_0104;
        tick();
        check("w64.valid", 64'(f1_out.valid), 64'd1);
        check("w64.instr", f1_out.instr, 64'h1234_5678_9ABC_DEF0);
        check("w64.pc", f1_out.pc, 64'hDEAD_BEEF_0000_0100);
        check("w64.pc_plus", f1_out.pc_plus, 64'hDEAD_BEEF_0000_0104);
        f1_in.valid = 1'b0;
        tick();
        check("w64_hold.valid", 64'(f1_out.valid), 64'd0);
        check("w64_hold.occ", 64'(occ1), 64'd0);
        check("w64_hold.instr", f1_out.instr, 64'h13);
        check("w64_hold.pc", f1_out.pc, 64'hDEAD_BEEF_0000_0100);
        check("w64_hold.pc_plus", f1_out.pc_plus, 64'hDEAD_BEEF_0000_0104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_decode_skid.md
FETCH_DECODE_SKID -- requirements
Module: fetch_decode_skid

Interface
- REQ-001: Parameter DATA_WIDTH, default 32, SHALL set the width of instruction, PC and PC+4 fields.
- REQ-002: Parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), SHALL be the instruction value presented when no valid instruction is held.
- REQ-003: Parameter ZERO_PC_ON_BUBBLE, default 1, SHALL select whether PC fields read 0 (1) or hold their last value (0) when out_valid is 0.
- REQ-004: clk  input  1  sole clock, all state updates on rising edge.
- REQ-005: rst_n  input  1  asynchronous, active-low reset.
- REQ-006: flush  input  1  synchronous discard of all held and incoming entries (branch/jump mispredict).
- REQ-007: in_valid  input  1  fetch stage offers an entry.
- REQ-008: in_ready  output  1  block can accept an entry this cycle.
- REQ-009: in_instr, in_pc, in_pc_plus  input  DATA_WIDTH each  fetched instruction, its PC, and its PC+4.
- REQ-010: out_valid  output  1  decode-side entry is valid.
- REQ-011: out_ready  input  1  decode stage consumes the entry this cycle (low = stall).
- REQ-012: out_instr, out_pc, out_pc_plus  output  DATA_WIDTH each  decode-side entry.
- REQ-013: occ  output  2  number of valid entries held (0..2).

Function
- REQ-014: Storage SHALL be two entries: main register (drives outputs) and skid register, each with its own valid bit.
- REQ-015: in_ready SHALL equal NOT skid_valid, driven directly from a flop with no combinational path from out_ready.
- REQ-016: Accept SHALL occur when in_valid && in_ready; drain SHALL occur when out_valid && out_ready.
- REQ-017: Outputs SHALL be driven directly from the main register; out_valid = main_valid.
- REQ-018: Accept with main empty, or with main draining and skid empty, SHALL load main next cycle (latency 1 cycle input to output).
- REQ-019: Accept with main valid and not draining SHALL load skid; occ becomes 2 and in_ready drops next cycle.
- REQ-020: Drain with skid valid SHALL move skid into main and clear skid_valid next cycle; no accept can coincide, since in_ready is 0.
- REQ-021: Drain with skid empty and no accept SHALL clear main_valid.
- REQ-022: Entries SHALL leave in acceptance order; none dropped or duplicated without flush.
- REQ-023: While out_valid=0, out_instr SHALL equal NOP_INSTR, and out_pc/out_pc_plus SHALL follow REQ-003.
- REQ-024: flush SHALL clear main_valid and skid_valid next cycle, overriding any simultaneous accept or drain; an entry offered in the flush cycle is discarded.
- REQ-025: A drain coinciding with flush SHALL still count as consumed by decode in that cycle.
- REQ-026: occ SHALL equal main_valid + skid_valid at all times.
- REQ-027: Payload registers SHALL load only when their valid bit is set, to minimise toggling.

Reset
- REQ-028: While rst_n=0, the block SHALL force main_valid=0, skid_valid=0, in_ready=1, occ=0, out_instr=NOP_INSTR, out_pc=0 and out_pc_plus=0, independent of clk.
- REQ-029: The first accept SHALL be possible on the first rising edge with rst_n=1.
- REQ-030: Reset asserted mid-operation SHALL discard both entries immediately.

Verification
- REQ-031: Streaming: out_ready=1, in_valid=1 every cycle, PC=0x0,0x4,0x8 -> outputs show the same PCs one cycle later, in order; occ stays 1 and in_ready stays 1.
- REQ-032: Stall fill: out_ready=0 for 3 cycles with in_valid=1 (PC 0x10, 0x14, 0x18) -> main=0x10, skid=0x14, occ=2, in_ready=0, and 0x18 is held at the source.
- REQ-033: Stall release: from the state in REQ-032, out_ready=1 -> out_pc sequence 0x10, 0x14, 0x18 with no gap or repeat.
- REQ-034: Flush with occ=2 plus a simultaneous accept (PC 0x20) -> next cycle occ=0, out_valid=0, out_instr=0x00000013, out_pc=0, and 0x20 never appears.
- REQ-035: Async reset pulsed mid-cycle with occ=2 -> outputs go to reset values before the next clock edge; an accept on the first edge after release appears one cycle later.
- REQ-036: Parameters DATA_WIDTH=64 and ZERO_PC_ON_BUBBLE=0 -> upper bits propagate intact, and out_pc holds its last value after the drain.
